// File: rtl/dft_pkg.sv
// Shared types and constants for the DFT configuration/sample driver.
package dft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_MARK,
        ST_CFG_BIN,
        ST_RUN_IDLE,
        ST_RUN_WR,
        ST_RUN_WAIT
    } dft_state_e;

    // Default transform length; the same value on o_k (MSB only) marks a new bin table.
    localparam int unsigned DFT_N_MAX = 8192;

endpackage

// File: rtl/dft_driver.sv
// Programs bin indices and length into a DFT core, then streams samples to it
// one at a time, waiting for completion (with timeout) between writes.
module dft_driver
    import dft_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned BIN_NUM   = 4,
    parameter int unsigned N_MAX     = DFT_N_MAX,
    parameter int unsigned LOG_N_MAX = $clog2(N_MAX),
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                                 i_sys_clk,
    input  logic                                 i_sys_rst_n,
    input  logic                                 i_cfg_start,
    input  logic [BIN_NUM-1:0][LOG_N_MAX-1:0]    i_k_table,
    input  logic [$clog2(LOG_N_MAX)-1:0]         i_N_cfg,
    input  logic                                 i_s_valid,
    output logic                                 o_s_ready,
    input  logic signed [WIDTH-1:0]              i_s_data,
    output logic [LOG_N_MAX:0]                   o_k,
    output logic [$clog2(LOG_N_MAX)-1:0]         o_N,
    output logic signed [WIDTH-1:0]              o_x,
    output logic                                 o_wr,
    input  logic                                 i_done,
    output logic                                 o_cfg_done,
    output logic                                 o_err,
    output logic [15:0]                          o_sample_cnt
);

    localparam int unsigned KW = LOG_N_MAX + 1;
    localparam int unsigned BW = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    dft_state_e                            r_state, w_next;
    logic [BW-1:0]                         r_bin, w_next_bin;
    logic [TW-1:0]                         r_wait, w_next_wait;
    logic [BIN_NUM-1:0][LOG_N_MAX-1:0]     r_k_tab;
    logic [$clog2(LOG_N_MAX)-1:0]          r_n_cfg;
    logic                                  w_cfg, w_take, w_timeout;

    // State register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_bin   <= w_next_bin;
            r_wait  <= w_next_wait;
        end
    end

    // Next-state logic; r_wait is zero in the first wait cycle so i_done is ignored there
    always_comb begin
        w_next      = r_state;
        w_next_bin  = r_bin;
        w_next_wait = '0;
        w_cfg       = 1'b0;
        w_take      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_cfg_start) begin
                    w_next = ST_CFG_MARK;
                    w_cfg  = 1'b1;
                end
            end
            ST_CFG_MARK: begin
                w_next     = ST_CFG_BIN;
                w_next_bin = '0;
            end
            ST_CFG_BIN: begin
                if (r_bin == BW'(BIN_NUM - 1)) begin
                    w_next = ST_RUN_IDLE;
                end else begin
                    w_next_bin = r_bin + BW'(1);
                end
            end
            ST_RUN_IDLE: begin
                if (i_cfg_start) begin
                    w_next = ST_CFG_MARK;
                    w_cfg  = 1'b1;
                end else if (i_s_valid) begin
                    w_next = ST_RUN_WR;
                    w_take = 1'b1;
                end
            end
            ST_RUN_WR: begin
                if (i_cfg_start) begin
                    w_next = ST_CFG_MARK;
                    w_cfg  = 1'b1;
                end else begin
                    w_next = ST_RUN_WAIT;
                end
            end
            ST_RUN_WAIT: begin
                if (i_cfg_start) begin
                    w_next = ST_CFG_MARK;
                    w_cfg  = 1'b1;
                end else if ((r_wait != '0) && i_done) begin
                    w_next = ST_RUN_IDLE;
                end else if (r_wait == TW'(TIMEOUT - 1)) begin
                    w_next    = ST_RUN_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next_wait = r_wait + TW'(1);
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_k_tab      <= '0;
            r_n_cfg      <= '0;
            o_k          <= '0;
            o_N          <= '0;
            o_x          <= '0;
            o_wr         <= 1'b0;
            o_s_ready    <= 1'b0;
            o_cfg_done   <= 1'b0;
            o_err        <= 1'b0;
            o_sample_cnt <= '0;
        end else begin
            o_s_ready  <= (w_next == ST_RUN_IDLE);
            o_wr       <= (w_next == ST_RUN_WR);
            o_cfg_done <= (w_next == ST_RUN_IDLE) || (w_next == ST_RUN_WR) ||
                          (w_next == ST_RUN_WAIT);
            if (w_cfg) begin
                r_k_tab <= i_k_table;
                r_n_cfg <= i_N_cfg;
            end
            if (w_next == ST_CFG_MARK) begin
                o_k <= KW'(N_MAX);
            end else if (w_next == ST_CFG_BIN) begin
                o_k <= {1'b0, r_k_tab[w_next_bin]};
                if (w_next_bin == BW'(BIN_NUM - 1)) begin
                    o_N <= r_n_cfg;
                end
            end
            if (w_take) begin
                o_x <= i_s_data;
            end
            if (w_timeout) begin
                o_err <= 1'b1;
            end
            if (w_cfg) begin
                o_sample_cnt <= '0;
            end else if (w_next == ST_RUN_WR) begin
                o_sample_cnt <= o_sample_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dft_driver.sv
// Scoreboard bench for dft_driver: directed configuration, sample, timeout and reset cases.
module tb_dft_driver;

    logic                 clk;
    logic                 rst_n;
    logic                 i_cfg_start;
    logic [3:0][12:0]     i_k_table;
    logic [3:0]           i_N_cfg;
    logic                 i_s_valid;
    logic                 o_s_ready;
    logic signed [11:0]   i_s_data;
    logic [13:0]          o_k;
    logic [3:0]           o_N;
    logic signed [11:0]   o_x;
    logic                 o_wr;
    logic                 i_done;
    logic                 o_cfg_done;
    logic                 o_err;
    logic [15:0]          o_sample_cnt;

    typedef struct packed {
        logic [11:0] x;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  prev_n  = '0;
    logic        prev_wr = 1'b0;

    dft_driver dut (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .i_cfg_start  (i_cfg_start),
        .i_k_table    (i_k_table),
        .i_N_cfg      (i_N_cfg),
        .i_s_valid    (i_s_valid),
        .o_s_ready    (o_s_ready),
        .i_s_data     (i_s_data),
        .o_k          (o_k),
        .o_N          (o_N),
        .o_x          (o_x),
        .o_wr         (o_wr),
        .i_done       (i_done),
        .o_cfg_done   (o_cfg_done),
        .o_err        (o_err),
        .o_sample_cnt (o_sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][12:0] mk_tab(input int a, input int b, input int c, input int d);
        logic [3:0][12:0] t;
        t[0] = 13'(a);
        t[1] = 13'(b);
        t[2] = 13'(c);
        t[3] = 13'(d);
        return t;
    endfunction

    // Monitor: every write strobe must match the next scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_wr) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wr: got o_x=%0d with empty scoreboard at %0t", o_x, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_x", 32'(o_x), 32'(e.x));
                    chk("wr_cnt", 32'(o_sample_cnt), 32'(e.cnt));
                end
                chk("wr_single", 32'(prev_wr), 32'd0);
            end
            prev_wr = o_wr;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!o_s_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!o_s_ready) chk("ready_timeout", 32'(o_s_ready), 32'd1);
    endtask

    task automatic wait_wr();
        int n = 0;
        @(negedge clk);
        while (!o_wr && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!o_wr) chk("wr_timeout", 32'(o_wr), 32'd1);
    endtask

    task automatic send(input logic signed [11:0] x, input logic done_now);
        wait_ready();
        i_s_valid = 1'b1;
        i_s_data  = x;
        if (done_now) i_done = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        sb_q.push_back({x, exp_cnt});
        @(posedge clk);
        #1;
        i_s_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0][12:0] tab, input logic [3:0] n,
                          input logic with_valid, input logic cfg_in_bin);
        @(negedge clk);
        i_cfg_start = 1'b1;
        i_k_table   = tab;
        i_N_cfg     = n;
        i_s_valid   = with_valid;
        i_s_data    = 12'sd9;
        exp_cnt     = '0;
        @(posedge clk);
        #1;
        i_cfg_start = 1'b0;
        i_s_valid   = 1'b0;
        @(negedge clk);
        chk("k_mark", 32'(o_k), 32'd8192);
        chk("mark_ready", 32'(o_s_ready), 32'd0);
        chk("mark_cfg_done", 32'(o_cfg_done), 32'd0);
        chk("mark_cnt", 32'(o_sample_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cfg_in_bin) i_cfg_start = (i == 0);
            chk("k_bin", 32'(o_k), 32'(tab[i]));
            chk("n_out", 32'(o_N), (i == 3) ? 32'(n) : 32'(prev_n));
        end
        i_cfg_start = 1'b0;
        prev_n = n;
        @(negedge clk);
        chk("run_cfg_done", 32'(o_cfg_done), 32'd1);
        chk("run_ready", 32'(o_s_ready), 32'd1);
        chk("k_hold", 32'(o_k), 32'(tab[3]));
    endtask

    initial begin
        logic bad;
        rst_n       = 1'b0;
        i_cfg_start = 1'b0;
        i_k_table   = '0;
        i_N_cfg     = '0;
        i_s_valid   = 1'b0;
        i_s_data    = '0;
        i_done      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_k", 32'(o_k), 32'd0);
        chk("rst_ready", 32'(o_s_ready), 32'd0);
        chk("rst_cfg_done", 32'(o_cfg_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cnt", 32'(o_sample_cnt), 32'd0);
        rst_n = 1'b1;
        i_s_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_ready", 32'(o_s_ready), 32'd0);
        i_s_valid = 1'b0;

        do_cfg(mk_tab(0, 1, 2, 3), 4'd2, 1'b0, 1'b0);

        // Four samples, completion 60 cycles after each write; valid held high while busy
        for (int s = 0; s < 4; s++) begin
            send(12'(s % 2), 1'b0);
            wait_wr();
            i_s_valid = 1'b1;
            i_s_data  = 12'sd7;
            repeat (60) @(negedge clk);
            i_done    = 1'b1;
            i_s_valid = 1'b0;
            @(negedge clk);
            i_done = 1'b0;
        end
        wait_ready();
        chk("cnt_after_4", 32'(o_sample_cnt), 32'd4);
        chk("x_hold", 32'(o_x), 32'd1);
        chk("no_err", 32'(o_err), 32'd0);

        // No completion: timeout after 255 wait cycles
        send(12'sd3, 1'b0);
        wait_wr();
        repeat (255) @(negedge clk);
        chk("pre_to_err", 32'(o_err), 32'd0);
        chk("pre_to_ready", 32'(o_s_ready), 32'd0);
        @(negedge clk);
        chk("to_err", 32'(o_err), 32'd1);
        chk("to_ready", 32'(o_s_ready), 32'd1);

        // i_done already high during the write: only the second wait cycle may return
        send(12'sd4, 1'b1);
        wait_wr();
        @(negedge clk);
        chk("done_wait1", 32'(o_s_ready), 32'd0);
        @(negedge clk);
        chk("done_wait2", 32'(o_s_ready), 32'd0);
        @(negedge clk);
        chk("done_back", 32'(o_s_ready), 32'd1);
        chk("err_sticky", 32'(o_err), 32'd1);
        chk("x_last", 32'(o_x), 32'd4);
        i_done = 1'b0;

        // Reconfigure coincident with a valid sample; cfg pulse inside CFG_BIN is ignored
        do_cfg(mk_tab(5, 6, 7, 8), 4'd3, 1'b1, 1'b1);
        chk("recfg_cnt", 32'(o_sample_cnt), 32'd0);

        // Reset in the middle of bin programming
        @(negedge clk);
        i_cfg_start = 1'b1;
        i_k_table   = mk_tab(9, 10, 11, 12);
        i_N_cfg     = 4'd1;
        @(posedge clk);
        #1;
        i_cfg_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_bin0", 32'(o_k), 32'd9);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_k", 32'(o_k), 32'd0);
        chk("arst_n", 32'(o_N), 32'd0);
        chk("arst_x", 32'(o_x), 32'd0);
        chk("arst_wr", 32'(o_wr), 32'd0);
        chk("arst_ready", 32'(o_s_ready), 32'd0);
        chk("arst_cfg_done", 32'(o_cfg_done), 32'd0);
        chk("arst_err", 32'(o_err), 32'd0);
        chk("arst_cnt", 32'(o_sample_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        prev_n = '0;
        bad    = 1'b0;
        i_s_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (o_k != '0 || o_s_ready || o_cfg_done) bad = 1'b1;
        end
        i_s_valid = 1'b0;
        chk("post_rst_quiet", 32'(bad), 32'd0);

        do_cfg(mk_tab(0, 1, 2, 3), 4'd2, 1'b0, 1'b0);
        send(12'sd2, 1'b0);
        wait_wr();
        repeat (5) @(negedge clk);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        @(negedge clk);
        chk("final_ready", 32'(o_s_ready), 32'd1);
        chk("final_cnt", 32'(o_sample_cnt), 32'd1);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dft_driver.md
DFT_DRIVER -- requirements
Module: dft_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample width in bits (signed).
REQ-002 SHALL have parameter BIN_NUM, default 4, number of bins to program.
REQ-003 SHALL have parameter N_MAX, default 8192, maximum transform length.
REQ-004 SHALL have parameter LOG_N_MAX, default $clog2(N_MAX), k index width.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles to wait for i_done.
REQ-006 SHALL have port i_sys_clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have port i_sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_cfg_start, input, 1, one-cycle request to (re)program the DFT.
REQ-009 SHALL have port i_k_table, input, BIN_NUM x LOG_N_MAX, bin indices to load.
REQ-010 SHALL have port i_N_cfg, input, $clog2(LOG_N_MAX), length code.
REQ-011 SHALL have port i_s_valid / o_s_ready / i_s_data, input/output/input signed WIDTH, upstream sample stream.
REQ-012 SHALL have port o_k, output, LOG_N_MAX+1, k bus to the DFT.
REQ-013 SHALL have port o_N, output, $clog2(LOG_N_MAX), length to the DFT.
REQ-014 SHALL have port o_x / o_wr, output signed WIDTH / 1, sample and write strobe to the DFT.
REQ-015 SHALL have port i_done, input, 1, DFT completion flag.
REQ-016 SHALL have port o_cfg_done / o_err / o_sample_cnt, output 1 / 1 / 16: configured, sticky timeout, samples written.

Function
REQ-017 SHALL implement states IDLE, CFG_MARK, CFG_BIN, RUN_IDLE, RUN_WR, RUN_WAIT.
REQ-018 SHALL in IDLE hold o_s_ready=0 and o_wr=0 until i_cfg_start=1, then go to CFG_MARK and latch i_k_table and i_N_cfg.
REQ-019 SHALL drive o_k=N_MAX (MSB set, rest 0) for exactly one cycle in CFG_MARK.
REQ-020 SHALL in CFG_BIN drive o_k={1'b0,k_table[i]} for i=0..BIN_NUM-1 on consecutive cycles (BIN_NUM cycles), then enter RUN_IDLE.
REQ-021 SHALL drive o_N from the latched i_N_cfg from the CFG_BIN cycle with i=BIN_NUM-1 onward; o_k SHALL hold the last bin value afterwards.
REQ-022 SHALL assert o_cfg_done in RUN_IDLE, RUN_WR and RUN_WAIT only.
REQ-023 SHALL assert o_s_ready only in RUN_IDLE; a transfer occurs when i_s_valid and o_s_ready are both 1 at a rising edge.
REQ-024 SHALL on a transfer register o_x=i_s_data and enter RUN_WR, in which o_wr=1 for exactly one cycle.
REQ-025 SHALL in RUN_WAIT ignore i_done during the first cycle, then return to RUN_IDLE on the first later cycle with i_done=1.
REQ-026 SHALL count RUN_WAIT cycles; at TIMEOUT set o_err (sticky until reset) and return to RUN_IDLE.
REQ-027 SHALL increment o_sample_cnt by 1 per RUN_WR cycle, wrapping 16'hFFFF->0, and clear it on i_cfg_start.
REQ-028 SHALL honour i_cfg_start in any RUN state by aborting the current sample and entering CFG_MARK the next cycle; i_cfg_start in CFG states SHALL be ignored.
REQ-029 SHALL give i_cfg_start priority over a simultaneous transfer in RUN_IDLE (no transfer; o_s_ready already 0 next cycle).
REQ-030 SHALL hold o_x stable from RUN_WR until the next transfer.

Reset
REQ-031 SHALL on i_sys_rst_n=0 immediately set state IDLE, o_k=0, o_N=0, o_x=0, o_wr=0, o_s_ready=0, o_cfg_done=0, o_err=0, o_sample_cnt=0, timeout counter 0.
REQ-032 SHALL after reset release require a new i_cfg_start before accepting samples; reset mid-CFG or mid-RUN discards all progress.

Structure
REQ-033 SHALL place the state enum and the marker constant (N_MAX encoding) in the shared package dft_pkg.
REQ-034 SHALL be a single module; no sub-module is required.

Verification
REQ-035 SHALL check: i_cfg_start, k_table={0,1,2,3}, N_cfg=2 -> o_k sequence 8192,0,1,2,3 on 5 consecutive cycles, o_N=2, then o_cfg_done=1.
REQ-036 SHALL check: samples 0,1,0,1 with i_done pulsed 60 cycles after each o_wr -> four single-cycle o_wr with o_x 0,1,0,1, o_sample_cnt=4.
REQ-037 SHALL check: i_done held 0 after a write -> o_err=1 after 255 wait cycles, o_s_ready=1 next cycle.
REQ-038 SHALL check: i_cfg_start coincident with i_s_valid in RUN_IDLE -> no o_wr, CFG_MARK next cycle, o_sample_cnt=0.
REQ-039 SHALL check: i_sys_rst_n low during CFG_BIN -> all outputs 0 asynchronously, no o_k activity until a new i_cfg_start.
REQ-040 SHALL check: i_done=1 already high in the o_wr cycle and the one after -> return to RUN_IDLE only on the second RUN_WAIT cycle.
